// File: rtl/dblcd_fb_writer.sv
// dblcd_fb_writer
//   Framebuffer write stage for the DragonBall LCDC STN pins. The async LCD
//   signals are synchronized into clk. Each lck falling edge captures one
//   4-bit pixel group. Eight groups are packed into a 32-bit word, MSB nibble
//   first. Completed words are queued with their word address in a small FIFO
//   and drained through a valid/ready write port. The block also reports frame
//   starts, the word count of the previous frame and a sticky overflow flag.
//
//   Optional feature macro: DBLCD_FB_WRITER_LINEPAD_EN
//     When defined, an llp falling edge flushes a partial word, zero-padded,
//     so that every line starts on a word boundary.
//
// Ports
//   clk, rst           system clock, asynchronous active-high reset
//   lflm, llp, lck     LCD first-line marker, line pulse, pixel clock (async)
//   ld[3:0]            LCD pixel data, 4 pixels at 1 bpp (async)
//   wr_addr, wr_data   registered framebuffer write address and data
//   wr_valid, wr_ready write handshake; transfer when both are high
//   frame_start        one-cycle pulse on a synchronized lflm rising edge
//   frame_words        words generated in the previous frame
//   overflow           sticky: a completed word was dropped on a full FIFO
module dblcd_fb_writer #(
   parameter int ADDR_WIDTH  = 16,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  lflm,
   input  logic                  llp,
   input  logic                  lck,
   input  logic [3:0]            ld,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [31:0]           wr_data,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic                  frame_start,
   output logic [ADDR_WIDTH-1:0] frame_words,
   output logic                  overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [31:0]           data;
   } entry_t;

   // Bit 0 is the newest sample. For the control pins, the top bit is an
   // extra history flop used for edge detection. For ld, the top stage is the
   // one-cycle-older sample, so the data is stable when the lck edge is seen.
   logic [SYNC_STAGES:0]      lck_sr, llp_sr, lflm_sr;
   logic [SYNC_STAGES:0][3:0] ld_sr;

   // NOTE: state registers use non-blocking assignments so that every flop
   // samples the pre-edge values, independent of process ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lck_sr  <= '0;
         llp_sr  <= '0;
         lflm_sr <= '0;
         ld_sr   <= '0;
      end else begin
         lck_sr  <= {lck_sr[SYNC_STAGES-1:0], lck};
         llp_sr  <= {llp_sr[SYNC_STAGES-1:0], llp};
         lflm_sr <= {lflm_sr[SYNC_STAGES-1:0], lflm};
         ld_sr   <= {ld_sr[SYNC_STAGES-1:0], ld};
      end
   end

   logic       cap_evt, line_end, fs_evt;
   logic [3:0] ld_s;

   assign cap_evt  = lck_sr[SYNC_STAGES]   & ~lck_sr[SYNC_STAGES-1];
   assign line_end = llp_sr[SYNC_STAGES]   & ~llp_sr[SYNC_STAGES-1];
   assign fs_evt   = ~lflm_sr[SYNC_STAGES] &  lflm_sr[SYNC_STAGES-1];
   assign ld_s     = ld_sr[SYNC_STAGES];

   // ---------------- packing and address counter ----------------
   logic [2:0]            n_q, n_c;
   logic [ADDR_WIDTH-1:0] addr_q, addr_c;
   logic [31:0]           part_q, part_c;
   logic                  push_w;
   entry_t                push_e;

   // Events are applied in priority order: frame start, then capture, then
   // the optional line flush. Each step sees the result of the previous one.
   // NOTE: every variable gets a default at the top of the block, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      n_c    = n_q;
      addr_c = addr_q;
      part_c = part_q;
      push_w = 1'b0;
      push_e = {addr_q, part_q};
      if (fs_evt) begin
         n_c    = '0;
         addr_c = '0;
         part_c = '0;
      end
      if (cap_evt) begin
         // A new word starts from zero, so unfilled low nibbles read as 0.
         if (n_c == 3'd0) part_c = '0;
         part_c = part_c | ({ld_s, 28'd0} >> {n_c, 2'b00});
         if (n_c == 3'd7) begin
            push_w = 1'b1;
            push_e = {addr_c, part_c};
            addr_c = addr_c + ADDR_WIDTH'(1);
            n_c    = '0;
         end else begin
            n_c = n_c + 3'd1;
         end
      end
`ifdef DBLCD_FB_WRITER_LINEPAD_EN
      if (line_end && n_c != 3'd0) begin
         push_w = 1'b1;
         push_e = {addr_c, part_c};
         addr_c = addr_c + ADDR_WIDTH'(1);
         n_c    = '0;
      end
`endif
   end

`ifndef DBLCD_FB_WRITER_LINEPAD_EN
   // llp only affects packing when line padding is built in.
   logic unused_line_end;
   assign unused_line_end = line_end;
`endif

   // ---------------- write FIFO ----------------
   entry_t           mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
   logic [CNT_W-1:0] count, cnt_pop, cnt_nxt;
   logic             pop, full, push_ok, drop;
   entry_t           head_nxt;

   assign pop     = wr_valid & wr_ready;
   assign full    = (count == CNT_W'(FIFO_DEPTH));
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign push_ok = push_w & (~full | pop);
   assign drop    = push_w & full & ~pop;

   // The output registers are loaded with the next head. When the FIFO will
   // be empty after the pop, the incoming word bypasses straight to them.
   always_comb begin
      cnt_pop = count;
      rd_nxt  = rd_ptr;
      if (pop) begin
         cnt_pop = count - CNT_W'(1);
         rd_nxt  = rd_ptr + PTR_W'(1);
      end
      cnt_nxt  = push_ok ? cnt_pop + CNT_W'(1) : cnt_pop;
      head_nxt = (cnt_pop == '0) ? push_e : mem[rd_nxt];
   end

   // NOTE: the storage array has no reset. The pointers and count define
   // which entries are live, and a reset on the array would only add cost.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_e;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q         <= '0;
         addr_q      <= '0;
         part_q      <= '0;
         frame_start <= 1'b0;
         frame_words <= '0;
         overflow    <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         wr_valid    <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
      end else begin
         n_q         <= n_c;
         addr_q      <= addr_c;
         part_q      <= part_c;
         frame_start <= fs_evt;
         if (fs_evt) frame_words <= addr_q;
         if (drop) overflow <= 1'b1;
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr      <= rd_nxt;
         count       <= cnt_nxt;
         wr_valid    <= (cnt_nxt != '0);
         if (cnt_nxt != '0) {wr_addr, wr_data} <= head_nxt;
      end
   end

endmodule

// File: tb/tb_dblcd_fb_writer.sv
// Self-checking bench for dblcd_fb_writer (default parameters).
module tb_dblcd_fb_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        lflm = 1'b0, llp = 1'b0, lck = 1'b1;
   logic [3:0]  ld = 4'h0;
   logic [15:0] wr_addr;
   logic [31:0] wr_data;
   logic        wr_valid, wr_ready;
   logic        frame_start, overflow;
   logic [15:0] frame_words;

   logic ready_drv = 1'b0, ready_rand = 1'b0, rand_mode = 1'b0;
   assign wr_ready = rand_mode ? ready_rand : ready_drv;

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
   } wr_t;
   wr_t got[$];

   dblcd_fb_writer dut (
      .clk(clk), .rst(rst), .lflm(lflm), .llp(llp), .lck(lck), .ld(ld),
      .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .frame_start(frame_start),
      .frame_words(frame_words), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Transfers are recorded mid-cycle; inputs only change just after posedge.
   always @(negedge clk) begin
      if (!rst && wr_valid && wr_ready) got.push_back({wr_addr, wr_data});
   end

   always @(posedge clk) begin
      #1 ready_rand = 1'($urandom_range(0, 1));
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One pixel group: ld is set while lck is high, then lck falls.
   task automatic nibble(input logic [3:0] v);
      ld  = v;
      lck = 1'b1;
      tick(3);
      lck = 1'b0;
      tick(3);
   endtask

   task automatic line_pulse();
      llp = 1'b1;
      tick(3);
      llp = 1'b0;
      tick(4);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      lck = 1'b1; llp = 1'b0; lflm = 1'b0; ld = 4'h0;
      ready_drv = 1'b0; rand_mode = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(4);
      got.delete();
   endtask

   task automatic test_reset();
      tick(2);
      checks += 6;
      if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid: got %b expected 0", wr_valid); end
      if (wr_addr !== 16'h0) begin errors++; $display("FAIL reset_wr_addr: got %h expected 0", wr_addr); end
      if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
      if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
      if (frame_words !== 16'h0) begin errors++; $display("FAIL reset_frame_words: got %h expected 0", frame_words); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
   endtask

   task automatic test_basic_word();
      apply_reset();
      for (int i = 1; i <= 8; i++) nibble(4'(i));
      tick(2);
      checks += 4;
      if (wr_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", wr_valid); end
      if (wr_addr !== 16'h0) begin errors++; $display("FAIL basic_addr: got %h expected 0", wr_addr); end
      if (wr_data !== 32'h12345678) begin errors++; $display("FAIL basic_data: got %h expected 12345678", wr_data); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b expected 0", overflow); end
      ready_drv = 1'b1;
      tick(3);
      checks += 2;
      if (got.size() !== 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", got.size()); end
      if (wr_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b expected 0", wr_valid); end
   endtask

   task automatic test_overflow();
      logic [31:0] words[5];
      apply_reset();
      for (int w = 0; w < 5; w++) begin
         words[w] = '0;
         for (int i = 0; i < 8; i++) begin
            logic [3:0] v;
            v = 4'($urandom_range(0, 15));
            words[w] = (words[w] << 4) | 32'(v);
            nibble(v);
         end
      end
      tick(2);
      checks += 3;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      if (wr_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b expected 1", wr_valid); end
      if (wr_data !== words[0]) begin errors++; $display("FAIL ovf_held_data: got %h expected %h", wr_data, words[0]); end
      ready_drv = 1'b1;
      tick(8);
      checks++;
      if (got.size() !== 4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", got.size()); end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== {16'(i), words[i]}) begin
            errors++; $display("FAIL ovf_word%0d: got %h expected %h", i, got[i], {16'(i), words[i]});
         end
      end
      checks++;
      if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
   endtask

   task automatic test_frame();
      logic seen;
      apply_reset();
      ready_drv = 1'b1;
      for (int i = 0; i < 2400; i++) nibble(4'(i % 16));
      tick(4);
      checks += 2;
      if (got.size() !== 300) begin errors++; $display("FAIL frame_count: got %0d expected 300", got.size()); end
      else if (got[299].addr !== 16'd299) begin errors++; $display("FAIL frame_last_addr: got %0d expected 299", got[299].addr); end
      lflm = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (frame_start) begin seen = 1'b1; break; end
      end
      checks += 2;
      if (seen !== 1'b1) begin errors++; $display("FAIL frame_start_pulse: got %b expected 1", seen); end
      if (frame_words !== 16'd300) begin errors++; $display("FAIL frame_words: got %0d expected 300", frame_words); end
      tick(1);
      checks++;
      if (frame_start !== 1'b0) begin errors++; $display("FAIL frame_start_width: got %b expected 0", frame_start); end
      got.delete();
      for (int i = 0; i < 8; i++) nibble(4'(8 - i));
      tick(3);
      checks++;
      if (got.size() !== 1 || got[0] !== {16'h0, 32'h87654321}) begin
         errors++; $display("FAIL frame_next_word: got %0d words, first %h expected 0000_87654321", got.size(), got.size() ? got[0] : '0);
      end
   endtask

   task automatic test_linepad();
      apply_reset();
      ready_drv = 1'b1;
      nibble(4'hA); nibble(4'hB); nibble(4'hC);
      line_pulse();
`ifdef DBLCD_FB_WRITER_LINEPAD_EN
      checks++;
      if (got.size() !== 1 || got[0] !== {16'h0, 32'hABC00000}) begin
         errors++; $display("FAIL linepad_flush: got %0d words, first %h expected 0000_abc00000", got.size(), got.size() ? got[0] : '0);
      end
      for (int i = 1; i <= 8; i++) nibble(4'(i));
      tick(3);
      checks++;
      if (got.size() !== 2 || got[1] !== {16'h1, 32'h12345678}) begin
         errors++; $display("FAIL linepad_next: got %0d words, last %h expected 0001_12345678", got.size(), got.size() ? got[got.size()-1] : '0);
      end
`else
      checks++;
      if (got.size() !== 0) begin errors++; $display("FAIL nopad_idle: got %0d words expected 0", got.size()); end
      for (int i = 1; i <= 5; i++) nibble(4'(i));
      tick(3);
      checks++;
      if (got.size() !== 1 || got[0] !== {16'h0, 32'hABC12345}) begin
         errors++; $display("FAIL nopad_word: got %0d words, first %h expected 0000_abc12345", got.size(), got.size() ? got[0] : '0);
      end
`endif
   endtask

   task automatic test_simultaneous();
      apply_reset();
      ready_drv = 1'b1;
      for (int i = 1; i <= 11; i++) nibble(4'(i));
      ld  = 4'hF;
      lck = 1'b1;
      tick(3);
      lck  = 1'b0;
      lflm = 1'b1;
      tick(3);
      for (int i = 1; i <= 7; i++) nibble(4'(i));
      tick(3);
      checks += 2;
      if (frame_words !== 16'd1) begin errors++; $display("FAIL simul_frame_words: got %0d expected 1", frame_words); end
      if (got.size() !== 2 || got[1] !== {16'h0, 32'hF1234567}) begin
         errors++; $display("FAIL simul_word: got %0d words, last %h expected 0000_f1234567", got.size(), got.size() ? got[got.size()-1] : '0);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 16; i++) nibble(4'(i));
      tick(2);
      checks++;
      if (wr_valid !== 1'b1) begin errors++; $display("FAIL rstmid_queued: got %b expected 1", wr_valid); end
      rst = 1'b1;
      #1;
      checks++;
      if (wr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async: got %b expected 0", wr_valid); end
      tick(2);
      rst = 1'b0;
      ready_drv = 1'b1;
      tick(10);
      checks += 2;
      if (got.size() !== 0) begin errors++; $display("FAIL rstmid_no_writes: got %0d expected 0", got.size()); end
      if (wr_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got %b expected 0", wr_valid); end
      for (int i = 0; i < 8; i++) nibble(4'(15 - i));
      tick(3);
      checks++;
      if (got.size() !== 1 || got[0] !== {16'h0, 32'hFEDCBA98}) begin
         errors++; $display("FAIL rstmid_new_word: got %0d words, first %h expected 0000_fedcba98", got.size(), got.size() ? got[0] : '0);
      end
   endtask

   // Random pixel stream with random backpressure; expected words are built
   // from the nibble list: word k = nibbles 8k..8k+7, first nibble on top.
   task automatic test_random_stream();
      int nib[$];
      apply_reset();
      rand_mode = 1'b1;
      for (int i = 0; i < 240; i++) begin
         nib.push_back(int'($urandom_range(0, 15)));
         nibble(4'(nib[i]));
      end
      rand_mode = 1'b0;
      ready_drv = 1'b1;
      tick(10);
      checks += 2;
      if (got.size() !== 30) begin errors++; $display("FAIL rand_count: got %0d expected 30", got.size()); end
      if (overflow !== 1'b0) begin errors++; $display("FAIL rand_overflow: got %b expected 0", overflow); end
      for (int k = 0; k < 30 && k < got.size(); k++) begin
         logic [31:0] d;
         d = 0;
         for (int i = 0; i < 8; i++) d = d * 16 + 32'(nib[8*k + i]);
         checks++;
         if (got[k] !== {16'(k), d}) begin
            errors++; $display("FAIL rand_word%0d: got %h expected %h", k, got[k], {16'(k), d});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_word();
      test_overflow();
      test_frame();
      test_linepad();
      test_simultaneous();
      test_reset_mid();
      test_random_stream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dblcd_fb_writer.md
# dblcd_fb_writer

Framebuffer write stage that sits directly downstream of the DragonBall LCDC pins. It samples the asynchronous STN signals `lflm`, `llp`, `lck` and `ld` into the system clock domain and packs 4-bit pixel groups into 32-bit words. It then pushes the words, with word addresses, through a small FIFO to the framebuffer write port using a valid/ready handshake. It also reports frame boundaries, per-frame word count and a sticky overflow flag.

## Interface
- `ADDR_WIDTH`, 16: framebuffer word-address width.
- `FIFO_DEPTH`, 4: write FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: synchronizer flops per LCD input; ≥2.

- `clk`  in  1  system clock; must be ≥4× `lck` frequency.
- `rst`  in  1  reset, asynchronous, active-high.
- `lflm`  in  1  LCD first-line marker, async.
- `llp`  in  1  LCD line pulse, async.
- `lck`  in  1  LCD pixel clock, async.
- `ld`  in  4  LCD pixel data, async; 4 pixels, 1 bpp.
- `wr_addr`  out  ADDR_WIDTH  framebuffer word address.
- `wr_data`  out  32  packed pixel word.
- `wr_valid`  out  1  write request.
- `wr_ready`  in  1  framebuffer accepts when high with `wr_valid`.
- `frame_start`  out  1  one-cycle pulse on a synchronized `lflm` rising edge.
- `frame_words`  out  ADDR_WIDTH  word count of the previous frame, latched at `frame_start`.
- `overflow`  out  1  sticky; a completed word was dropped because the FIFO was full.

## Operation
- Synchronization:
  - Each input passes through `SYNC_STAGES` flops.
  - `ld` gets one extra flop stage relative to `lck`, so the data is stable when the edge is seen.
- Edge detection:
  - `lck` falling edge: capture event.
  - `llp` falling edge: line end.
  - `lflm` rising edge: frame start.
- Packing:
  - Nibble index `n` runs 0..7. Nibble 0 goes to `wr_data[31:28]`; nibble 7 goes to `[3:0]`.
  - On the capture event with `n`=7, the word is complete. It is pushed with the current word address, then the address increments and `n` returns to 0.
- Address counter:
  - Width `ADDR_WIDTH`; wraps modulo 2^ADDR_WIDTH.
  - Counts words generated, including dropped ones.
- Frame start:
  - Latch the address counter into `frame_words`.
  - Reset the address counter and `n` to 0.
  - Discard any partial word.
  - Words already in the FIFO still drain with their original addresses.
- Simultaneous frame start and capture in the same cycle: frame start is applied first, and the nibble is captured as nibble 0 at address 0.
- Full FIFO when a word completes:
  - The word is dropped and `overflow` sets.
  - `overflow` clears only on `rst`.
- FIFO:
  - Push and pop in the same cycle are allowed when full, because the pop frees the slot first.
  - Entry order is preserved.
- Reset values:
  - `wr_valid`=0, `wr_addr`=0, `wr_data`=0.
  - `frame_start`=0, `frame_words`=0, `overflow`=0.
  - FIFO empty, `n`=0, address counter 0.
  - Synchronizer flops 0.
- Reset mid-operation clears all state immediately, including queued words. No write completes after `rst` asserts.

## Timing
- Latency from an `lck` pin falling edge to its detection: `SYNC_STAGES`+1 clk.
- A completed word is visible on `wr_valid` 1 clk after detection of nibble 7, when the FIFO was empty.
- `wr_addr`, `wr_data` and `wr_valid` are registered FIFO outputs. They are held stable while `wr_valid`=1 and `wr_ready`=0.
- Transfer happens on a cycle where `wr_valid` and `wr_ready` are both high. The next entry is presented on the following clk.
- Sustained throughput: 1 word/clk.
- `frame_start` and the `frame_words` update occur in the same cycle.

## Configuration
- `DBLCD_FB_WRITER_LINEPAD_EN`
  - Defined:
    - A line end with `n`≠0 flushes the partial word, zero-padding the unfilled low nibbles. This follows the same push/drop rules as a complete word.
    - The address then increments and `n` resets, so each line starts word-aligned.
    - A line end with `n`=0 does nothing.
    - A line end coinciding with a capture processes the capture first, then the flush.
  - Undefined: `llp` is ignored for packing, and pixels stream continuously across lines.

## Test plan
- After `rst`, 8 `lck` edges with `ld`=1,2,…,8 -> one write: `wr_addr`=0, `wr_data`=0x12345678; `overflow`=0.
- `wr_ready` held 0, 5 full words generated with `FIFO_DEPTH`=4 -> the 5th is dropped and `overflow`=1. Then `wr_ready`=1 -> writes at addresses 0..3 in order, and the 5th word never appears.
- Frame of 300 words then an `lflm` rising edge -> `frame_start` pulse, `frame_words`=300, and the next word is written at address 0.
- LINEPAD on: 3 nibbles 0xA,0xB,0xC then `llp` -> `wr_data`=0xABC00000 at address 0, and the next line starts at address 1. LINEPAD off: the same stimulus writes nothing until 5 more nibbles arrive.
- `lflm` edge and `lck` edge detected in the same cycle with `ld`=0xF -> the first word after the frame has `wr_data[31:28]`=0xF at address 0.
- `rst` pulsed while 2 words are queued and `wr_valid`=1 -> `wr_valid` drops immediately, with no writes afterwards until new words complete.
